// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the dmem load/store master.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  // Access width in bytes for a size code.
  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

  // Byte enables across two consecutive doublewords: [7:0] first beat, [15:8] second beat.
  function automatic logic [15:0] byte_mask(input logic [1:0] size, input logic [2:0] off);
    logic [15:0] ones;
    case (size)
      SZ_B:    ones = 16'h0001;
      SZ_H:    ones = 16'h0003;
      SZ_W:    ones = 16'h000F;
      SZ_D:    ones = 16'h00FF;
      default: ones = 16'h0000;
    endcase
    return ones << off;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for stores and extract/extend for loads; purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [2:0]  off,
  input  logic        is_signed,
  input  logic        beat_hi,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata_lo,
  input  logic [63:0] rdata_hi,
  output logic [63:0] lane_wdata,
  output logic [63:0] lane_wmask,
  output logic [63:0] load_data
);

  logic [127:0] wide_wdata_s;
  logic [15:0]  bmask_s;
  logic [7:0]   lane_be_s;
  logic [63:0]  raw_s;

  // Shift store data and byte enables into the lanes of the current beat.
  always_comb begin
    wide_wdata_s = {64'h0, wdata} << {off, 3'b000};
    bmask_s      = byte_mask(size, off);
    if (beat_hi) begin
      lane_wdata = wide_wdata_s[127:64];
      lane_be_s  = bmask_s[15:8];
    end else begin
      lane_wdata = wide_wdata_s[63:0];
      lane_be_s  = bmask_s[7:0];
    end
    for (int i = 0; i < 8; i++) begin
      lane_wmask[8*i +: 8] = {8{lane_be_s[i]}};
    end
  end

  // Pull the addressed bytes out of the two doublewords and extend to 64 bits.
  always_comb begin
    raw_s = 64'({rdata_hi, rdata_lo} >> {off, 3'b000});
    case (size)
      SZ_B:    load_data = {{56{is_signed & raw_s[7]}},  raw_s[7:0]};
      SZ_H:    load_data = {{48{is_signed & raw_s[15]}}, raw_s[15:0]};
      SZ_W:    load_data = {{32{is_signed & raw_s[31]}}, raw_s[31:0]};
      SZ_D:    load_data = raw_s;
      default: load_data = 64'h0;
    endcase
  end

endmodule

// File: rtl/dmem_lsu_master.sv
// Single-outstanding load/store master issuing doubleword-aligned beats to dmem.
module dmem_lsu_master
  import lsu_pkg::*;
#(
  parameter logic [63:0] MEM_BASE = 64'h0000_0000_8000_0000,
  parameter logic [63:0] MEM_SIZE = 64'h0000_0000_0800_0000,
  parameter bit          SPLIT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        dmem_en,
  output logic [63:0] dmem_addr,
  input  logic [63:0] dmem_rdata,
  output logic [63:0] dmem_wdata,
  output logic [63:0] dmem_wmask,
  output logic        dmem_wen
);

  lsu_state_e  state_r;
  logic [63:0] addr_r, wdata_r, lo_r, resp_rdata_r;
  logic [1:0]  size_r;
  logic        signed_r, wen_r, cross_r;
  logic        req_ready_r, resp_valid_r, resp_err_r;

  logic [3:0]  req_nbytes_s;
  logic [64:0] req_end_s, win_end_s;
  logic        req_cross_s, req_err_s;
  logic        beat_s, beat_hi_s;
  logic [63:0] rd_lo_s, rd_hi_s, lane_wdata_s, lane_wmask_s, load_data_s;

  // Classify the offered request; the end address is 65 bits so a wrap past 2^64 is caught.
  always_comb begin
    req_nbytes_s = size_bytes(req_size);
    req_end_s    = {1'b0, req_addr} + {61'h0, req_nbytes_s} - 65'd1;
    win_end_s    = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};
    req_cross_s  = ({1'b0, req_addr[2:0]} + req_nbytes_s) > 4'd8;
    req_err_s    = (req_addr < MEM_BASE) | (req_end_s >= win_end_s) | (req_cross_s & ~SPLIT_EN);
  end

  // Select which read doubleword is live this cycle; the second beat pairs with the captured first.
  always_comb begin
    beat_s    = (state_r == ST_BEAT0) || (state_r == ST_BEAT1);
    beat_hi_s = (state_r == ST_BEAT1);
    if (beat_hi_s) begin
      rd_lo_s = lo_r;
      rd_hi_s = dmem_rdata;
    end else begin
      rd_lo_s = dmem_rdata;
      rd_hi_s = 64'h0;
    end
  end

  lsu_align u_align (
    .size       (size_r),
    .off        (addr_r[2:0]),
    .is_signed  (signed_r),
    .beat_hi    (beat_hi_s),
    .wdata      (wdata_r),
    .rdata_lo   (rd_lo_s),
    .rdata_hi   (rd_hi_s),
    .lane_wdata (lane_wdata_s),
    .lane_wmask (lane_wmask_s),
    .load_data  (load_data_s)
  );

  // Decode the dmem beat from registered state so an async reset silences it immediately.
  always_comb begin
    if (beat_s) begin
      dmem_en    = 1'b1;
      dmem_wen   = wen_r;
      dmem_addr  = {addr_r[63:3] + {60'h0, beat_hi_s}, 3'b000};
      dmem_wdata = wen_r ? lane_wdata_s : 64'h0;
      dmem_wmask = wen_r ? lane_wmask_s : 64'h0;
    end else begin
      dmem_en    = 1'b0;
      dmem_wen   = 1'b0;
      dmem_addr  = 64'h0;
      dmem_wdata = 64'h0;
      dmem_wmask = 64'h0;
    end
  end

  // Request/response sequencing with capture registers and registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      addr_r       <= 64'h0;
      wdata_r      <= 64'h0;
      lo_r         <= 64'h0;
      size_r       <= 2'd0;
      signed_r     <= 1'b0;
      wen_r        <= 1'b0;
      cross_r      <= 1'b0;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 64'h0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid && req_ready_r) begin
            addr_r      <= req_addr;
            wdata_r     <= req_wdata;
            size_r      <= req_size;
            signed_r    <= req_signed;
            wen_r       <= req_wen;
            cross_r     <= req_cross_s;
            req_ready_r <= 1'b0;
            if (req_err_s) begin
              state_r      <= ST_RESP;
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
              resp_rdata_r <= 64'h0;
            end else begin
              state_r <= ST_BEAT0;
            end
          end
        end
        ST_BEAT0: begin
          lo_r <= wen_r ? 64'h0 : dmem_rdata;
          if (cross_r) begin
            state_r <= ST_BEAT1;
          end else begin
            state_r      <= ST_RESP;
            resp_valid_r <= 1'b1;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= wen_r ? 64'h0 : load_data_s;
          end
        end
        ST_BEAT1: begin
          state_r      <= ST_RESP;
          resp_valid_r <= 1'b1;
          resp_err_r   <= 1'b0;
          resp_rdata_r <= wen_r ? 64'h0 : load_data_s;
        end
        ST_RESP: begin
          if (resp_ready) begin
            state_r      <= ST_IDLE;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 64'h0;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          req_ready_r  <= 1'b1;
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
          resp_rdata_r <= 64'h0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;
  assign resp_rdata = resp_rdata_r;

endmodule

// File: tb/tb_dmem_lsu_master.sv
// Self-checking bench for dmem_lsu_master: byte-level memory model plus directed and random traffic.
module tb_dmem_lsu_master;

  localparam logic [63:0] BASE     = 64'h0000_0000_8000_0000;
  localparam logic [63:0] SIZE     = 64'h0000_0000_0800_0000;
  localparam logic [63:0] U2_RDATA = 64'h8899_AABB_CCDD_EEFF;

  logic        clk, reset;
  logic        req_valid, req_ready, req_wen, req_signed, resp_valid, resp_ready, resp_err;
  logic        dmem_en, dmem_wen;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata, resp_rdata, dmem_addr, dmem_rdata, dmem_wdata, dmem_wmask;

  logic        u2_req_valid, u2_req_ready, u2_req_wen, u2_req_signed, u2_resp_valid, u2_resp_ready, u2_resp_err;
  logic        u2_dmem_en, u2_dmem_wen;
  logic [1:0]  u2_req_size;
  logic [63:0] u2_req_addr, u2_req_wdata, u2_resp_rdata, u2_dmem_addr, u2_dmem_rdata, u2_dmem_wdata, u2_dmem_wmask;

  logic [63:0] ram [64] = '{default: 64'h0};
  logic [7:0]  ref_mem [512];

  int          n_checks, n_fail;
  int          got_lat, got_nbeats;
  logic [63:0] b_addr [2];
  logic [63:0] b_mask [2];
  logic [63:0] b_wd [2];
  logic        b_wen [2];
  logic [63:0] got_rdata;
  logic        got_err, got_ready0;

  dmem_lsu_master #(.MEM_BASE(BASE), .MEM_SIZE(SIZE), .SPLIT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dmem_en(dmem_en), .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata), .dmem_wdata(dmem_wdata),
    .dmem_wmask(dmem_wmask), .dmem_wen(dmem_wen)
  );

  dmem_lsu_master #(.MEM_BASE(BASE), .MEM_SIZE(SIZE), .SPLIT_EN(1'b0)) dut_ns (
    .clk(clk), .reset(reset), .req_valid(u2_req_valid), .req_ready(u2_req_ready), .req_wen(u2_req_wen),
    .req_size(u2_req_size), .req_signed(u2_req_signed), .req_addr(u2_req_addr), .req_wdata(u2_req_wdata),
    .resp_valid(u2_resp_valid), .resp_ready(u2_resp_ready), .resp_rdata(u2_resp_rdata), .resp_err(u2_resp_err),
    .dmem_en(u2_dmem_en), .dmem_addr(u2_dmem_addr), .dmem_rdata(u2_dmem_rdata), .dmem_wdata(u2_dmem_wdata),
    .dmem_wmask(u2_dmem_wmask), .dmem_wen(u2_dmem_wen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dmem_rdata    = ram[dmem_addr[8:3]];
  assign u2_dmem_rdata = U2_RDATA;

  // RAM commits masked write lanes at the end of each write beat.
  always @(posedge clk) begin
    if (dmem_en && dmem_wen) begin
      for (int l = 0; l < 8; l++) begin
        if (dmem_wmask[8*l]) ram[dmem_addr[8:3]][8*l +: 8] <= dmem_wdata[8*l +: 8];
      end
    end
  end

  function automatic logic model_err(input logic [63:0] a, input logic [1:0] sz, input logic split);
    int n;
    n = 1 << sz;
    if (!split && (int'(a[2:0]) + n > 8)) return 1'b1;
    if (a < BASE) return 1'b1;
    return ((a - BASE) > (SIZE - 64'(n)));
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] a, input logic [1:0] sz, input logic sgn);
    int n;
    logic [63:0] v;
    logic [8:0] idx;
    n = 1 << sz;
    v = 64'h0;
    for (int k = 0; k < n; k++) begin
      idx = 9'(a + 64'(k));
      v[8*k +: 8] = ref_mem[idx];
    end
    if (sgn && n < 8 && v[8*n-1]) begin
      for (int k = n; k < 8; k++) v[8*k +: 8] = 8'hFF;
    end
    return v;
  endfunction

  task automatic model_store(input logic [63:0] a, input logic [1:0] sz, input logic [63:0] wd);
    logic [8:0] idx;
    for (int k = 0; k < (1 << sz); k++) begin
      idx = 9'(a + 64'(k));
      ref_mem[idx] = wd[8*k +: 8];
    end
  endtask

  // Offer one request, scramble req_* after the accept, and record every beat until resp_valid.
  task automatic drive_req(input logic wen, input logic [1:0] sz, input logic sgn,
                           input logic [63:0] a, input logic [63:0] wd);
    req_valid = 1'b1; req_wen = wen; req_size = sz; req_signed = sgn; req_addr = a; req_wdata = wd;
    got_ready0 = req_ready;
    @(posedge clk); #1;
    req_valid = 1'b0; req_wen = 1'($urandom_range(0, 1)); req_size = 2'($urandom_range(0, 3));
    req_signed = 1'($urandom_range(0, 1)); req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    got_lat = 1;
    got_nbeats = 0;
    while (!resp_valid && got_lat < 20) begin
      if (dmem_en) begin
        if (got_nbeats < 2) begin
          b_addr[got_nbeats] = dmem_addr; b_mask[got_nbeats] = dmem_wmask;
          b_wd[got_nbeats] = dmem_wdata; b_wen[got_nbeats] = dmem_wen;
        end
        got_nbeats++;
      end
      @(posedge clk); #1;
      got_lat++;
    end
    got_rdata = resp_rdata;
    got_err = resp_err;
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
    n_checks++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err got %b exp 0", resp_err); end
    n_checks++; if (resp_rdata !== 64'h0) begin n_fail++; $display("FAIL reset_resp_rdata got %h exp 0", resp_rdata); end
    n_checks++; if ({dmem_en, dmem_wen} !== 2'b00) begin n_fail++; $display("FAIL reset_dmem_en_wen got %b exp 00", {dmem_en, dmem_wen}); end
    n_checks++; if (dmem_addr !== 64'h0) begin n_fail++; $display("FAIL reset_dmem_addr got %h exp 0", dmem_addr); end
    n_checks++; if (dmem_wmask !== 64'h0 || dmem_wdata !== 64'h0) begin n_fail++; $display("FAIL reset_dmem_wmask_wdata got %h %h exp 0 0", dmem_wmask, dmem_wdata); end
  endtask

  task automatic test_directed();
    // word store into upper half of a doubleword, upper source bits must not leak
    drive_req(1'b1, 2'd2, 1'b0, 64'h8000_0004, 64'hDEAD_BEEF_1122_3344);
    n_checks++; if (got_nbeats !== 1) begin n_fail++; $display("FAIL sw_beats got %0d exp 1", got_nbeats); end
    n_checks++; if (b_addr[0] !== 64'h8000_0000) begin n_fail++; $display("FAIL sw_addr got %h exp 80000000", b_addr[0]); end
    n_checks++; if (b_mask[0] !== 64'hFFFF_FFFF_0000_0000) begin n_fail++; $display("FAIL sw_mask got %h exp ffffffff00000000", b_mask[0]); end
    n_checks++; if (b_wd[0][63:32] !== 32'h1122_3344 || b_wen[0] !== 1'b1) begin n_fail++; $display("FAIL sw_wdata got %h wen %b exp 11223344 wen 1", b_wd[0][63:32], b_wen[0]); end
    n_checks++; if (got_lat !== 2 || got_rdata !== 64'h0) begin n_fail++; $display("FAIL sw_lat_rdata got %0d %h exp 2 0", got_lat, got_rdata); end
    model_store(64'h8000_0004, 2'd2, 64'hDEAD_BEEF_1122_3344);
    finish_resp();
    drive_req(1'b1, 2'd0, 1'b0, 64'h8000_0007, 64'h0000_0000_0000_0080);
    model_store(64'h8000_0007, 2'd0, 64'h0000_0000_0000_0080);
    finish_resp();
    drive_req(1'b0, 2'd0, 1'b1, 64'h8000_0007, 64'h0);
    n_checks++; if (got_rdata !== 64'hFFFF_FFFF_FFFF_FF80 || got_nbeats !== 1) begin n_fail++; $display("FAIL lb_sign got %h beats %0d exp ffffffffffffff80 beats 1", got_rdata, got_nbeats); end
    finish_resp();
    drive_req(1'b0, 2'd0, 1'b0, 64'h8000_0007, 64'h0);
    n_checks++; if (got_rdata !== 64'h80) begin n_fail++; $display("FAIL lbu got %h exp 80", got_rdata); end
    finish_resp();
    // doubleword store straddling two doublewords
    drive_req(1'b1, 2'd3, 1'b0, 64'h8000_0005, 64'h0102_0304_0506_0708);
    n_checks++; if (got_nbeats !== 2 || got_lat !== 3) begin n_fail++; $display("FAIL sd_split beats %0d lat %0d exp 2 3", got_nbeats, got_lat); end
    n_checks++; if (b_addr[0] !== 64'h8000_0000 || b_addr[1] !== 64'h8000_0008) begin n_fail++; $display("FAIL sd_addrs got %h %h exp 80000000 80000008", b_addr[0], b_addr[1]); end
    n_checks++; if (b_mask[0] !== 64'hFFFF_FF00_0000_0000 || b_mask[1] !== 64'h0000_00FF_FFFF_FFFF) begin n_fail++; $display("FAIL sd_masks got %h %h exp ffffff0000000000 000000ffffffffff", b_mask[0], b_mask[1]); end
    n_checks++; if (b_wd[0][63:40] !== 24'h06_0708 || b_wd[1][39:0] !== 40'h01_0203_0405) begin n_fail++; $display("FAIL sd_wdata got %h %h exp 060708 0102030405", b_wd[0][63:40], b_wd[1][39:0]); end
    model_store(64'h8000_0005, 2'd3, 64'h0102_0304_0506_0708);
    finish_resp();
    drive_req(1'b0, 2'd3, 1'b0, 64'h8000_0005, 64'h0);
    n_checks++; if (got_rdata !== 64'h0102_0304_0506_0708 || got_lat !== 3) begin n_fail++; $display("FAIL ld_split got %h lat %0d exp 0102030405060708 lat 3", got_rdata, got_lat); end
    finish_resp();
    // window edges
    drive_req(1'b0, 2'd0, 1'b0, 64'h7FFF_FFFF, 64'h0);
    n_checks++; if (got_err !== 1'b1 || got_nbeats !== 0 || got_lat !== 1 || got_rdata !== 64'h0) begin n_fail++; $display("FAIL below_win err %b beats %0d lat %0d rd %h exp 1 0 1 0", got_err, got_nbeats, got_lat, got_rdata); end
    finish_resp();
    drive_req(1'b0, 2'd3, 1'b0, 64'h87FF_FFF9, 64'h0);
    n_checks++; if (got_err !== 1'b1 || got_nbeats !== 0) begin n_fail++; $display("FAIL above_win err %b beats %0d exp 1 0", got_err, got_nbeats); end
    finish_resp();
    drive_req(1'b0, 2'd3, 1'b0, 64'h87FF_FFF8, 64'h0);
    n_checks++; if (got_err !== 1'b0 || got_rdata !== model_load(64'h87FF_FFF8, 2'd3, 1'b0)) begin n_fail++; $display("FAIL top_of_win err %b rd %h exp 0 %h", got_err, got_rdata, model_load(64'h87FF_FFF8, 2'd3, 1'b0)); end
    finish_resp();
  endtask

  task automatic test_hold();
    logic [63:0] exp;
    exp = model_load(64'h8000_0004, 2'd2, 1'b1);
    resp_ready = 1'b0;
    drive_req(1'b0, 2'd2, 1'b1, 64'h8000_0004, 64'h0);
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== exp || resp_err !== 1'b0 || req_ready !== 1'b0 || dmem_en !== 1'b0) begin
        n_fail++; $display("FAIL hold_cycle%0d valid %b rd %h err %b rdy %b en %b exp 1 %h 0 0 0", c, resp_valid, resp_rdata, resp_err, req_ready, dmem_en, exp);
      end
      @(posedge clk); #1;
    end
    finish_resp();
    n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release valid %b rdy %b exp 0 1", resp_valid, req_ready); end
  endtask

  task automatic test_nosplit();
    logic [63:0] t_addr [3];
    logic [1:0]  t_size [3];
    logic        t_sgn [3];
    int n;
    logic saw_en;
    t_addr[0] = 64'h8000_0006; t_size[0] = 2'd2; t_sgn[0] = 1'b0;
    t_addr[1] = 64'h8000_0008; t_size[1] = 2'd3; t_sgn[1] = 1'b0;
    t_addr[2] = 64'h8000_000E; t_size[2] = 2'd1; t_sgn[2] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      u2_req_valid = 1'b1; u2_req_wen = 1'b0; u2_req_size = t_size[c]; u2_req_signed = t_sgn[c]; u2_req_addr = t_addr[c];
      @(posedge clk); #1;
      u2_req_valid = 1'b0;
      n = 1; saw_en = 1'b0;
      while (!u2_resp_valid && n < 20) begin
        if (u2_dmem_en) saw_en = 1'b1;
        @(posedge clk); #1;
        n++;
      end
      if (c == 0) begin
        n_checks++; if (saw_en !== 1'b0 || u2_resp_err !== 1'b1 || u2_resp_rdata !== 64'h0 || n !== 1) begin n_fail++; $display("FAIL nosplit_err en %b err %b rd %h lat %0d exp 0 1 0 1", saw_en, u2_resp_err, u2_resp_rdata, n); end
      end else if (c == 1) begin
        n_checks++; if (saw_en !== 1'b1 || u2_resp_err !== 1'b0 || u2_resp_rdata !== U2_RDATA || n !== 2) begin n_fail++; $display("FAIL nosplit_ld en %b err %b rd %h lat %0d exp 1 0 %h 2", saw_en, u2_resp_err, u2_resp_rdata, n, U2_RDATA); end
      end else begin
        n_checks++; if (u2_resp_err !== 1'b0 || u2_resp_rdata !== 64'hFFFF_FFFF_FFFF_8899) begin n_fail++; $display("FAIL nosplit_lh err %b rd %h exp 0 ffffffffffff8899", u2_resp_err, u2_resp_rdata); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_in_beat1();
    logic [63:0] x;
    x = {$urandom, $urandom};
    req_valid = 1'b1; req_wen = 1'b1; req_size = 2'd3; req_signed = 1'b0; req_addr = 64'h8000_0043; req_wdata = x;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (dmem_en !== 1'b1 || dmem_addr !== 64'h8000_0048) begin n_fail++; $display("FAIL beat1_reached en %b addr %h exp 1 80000048", dmem_en, dmem_addr); end
    reset = 1'b1;
    #1;
    n_checks++; if ({dmem_en, dmem_wen} !== 2'b00 || dmem_addr !== 64'h0 || dmem_wmask !== 64'h0 || dmem_wdata !== 64'h0) begin n_fail++; $display("FAIL reset_mid_beat en %b wen %b addr %h mask %h wd %h exp all 0", dmem_en, dmem_wen, dmem_addr, dmem_wmask, dmem_wdata); end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL after_reset rdy %b valid %b exp 1 0", req_ready, resp_valid); end
    // only the first five bytes (first beat) of the store reach memory
    model_store(64'h8000_0043, 2'd2, {32'h0, x[31:0]});
    model_store(64'h8000_0047, 2'd0, {56'h0, x[39:32]});
    drive_req(1'b0, 2'd3, 1'b0, 64'h8000_0040, 64'h0);
    n_checks++; if (got_rdata !== model_load(64'h8000_0040, 2'd3, 1'b0)) begin n_fail++; $display("FAIL partial_lo got %h exp %h", got_rdata, model_load(64'h8000_0040, 2'd3, 1'b0)); end
    finish_resp();
    drive_req(1'b0, 2'd3, 1'b0, 64'h8000_0048, 64'h0);
    n_checks++; if (got_rdata !== model_load(64'h8000_0048, 2'd3, 1'b0)) begin n_fail++; $display("FAIL partial_hi got %h exp %h", got_rdata, model_load(64'h8000_0048, 2'd3, 1'b0)); end
    finish_resp();
  endtask

  task automatic test_random();
    logic        wen, sgn, exp_err;
    logic [1:0]  sz;
    logic [63:0] a, wd, exp_rd, base_a;
    logic [63:0] e_mask [2];
    logic [63:0] e_wd [2];
    int n, exp_n, p;
    for (int it = 0; it < 300; it++) begin
      wen = 1'($urandom_range(0, 1)); sgn = 1'($urandom_range(0, 1)); sz = 2'($urandom_range(0, 3));
      wd = {$urandom, $urandom};
      case ($urandom_range(0, 9))
        0: a = BASE - 64'($urandom_range(1, 16));
        1: a = BASE + SIZE - 64'($urandom_range(1, 16));
        2: a = 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7));
        default: a = BASE + 64'($urandom_range(0, 255));
      endcase
      n = 1 << sz;
      exp_err = model_err(a, sz, 1'b1);
      exp_n = exp_err ? 0 : ((int'(a[2:0]) + n > 8) ? 2 : 1);
      exp_rd = (exp_err || wen) ? 64'h0 : model_load(a, sz, sgn);
      base_a = a & ~64'h7;
      e_mask[0] = 64'h0; e_mask[1] = 64'h0; e_wd[0] = 64'h0; e_wd[1] = 64'h0;
      for (int k = 0; k < n; k++) begin
        p = int'(a[2:0]) + k;
        e_mask[p/8][8*(p%8) +: 8] = 8'hFF;
        e_wd[p/8][8*(p%8) +: 8] = wd[8*k +: 8];
      end
      drive_req(wen, sz, sgn, a, wd);
      n_checks++;
      if (got_ready0 !== 1'b1 || got_lat >= 20 || got_err !== exp_err || got_rdata !== exp_rd || got_nbeats !== exp_n || got_lat !== exp_n + 1) begin
        n_fail++; $display("FAIL rand%0d a %h sz %0d wen %b: rdy %b err %b rd %h beats %0d lat %0d exp rdy 1 err %b rd %h beats %0d lat %0d",
                           it, a, sz, wen, got_ready0, got_err, got_rdata, got_nbeats, got_lat, exp_err, exp_rd, exp_n, exp_n + 1);
      end
      for (int b = 0; b < exp_n; b++) begin
        n_checks++;
        if (b_addr[b] !== base_a + 64'(8 * b) || b_wen[b] !== wen ||
            (wen && (b_mask[b] !== e_mask[b] || (b_wd[b] & e_mask[b]) !== e_wd[b]))) begin
          n_fail++; $display("FAIL rand%0d_beat%0d addr %h wen %b mask %h wd %h exp addr %h wen %b mask %h wd %h",
                             it, b, b_addr[b], b_wen[b], b_mask[b], b_wd[b], base_a + 64'(8 * b), wen, e_mask[b], e_wd[b]);
        end
      end
      if (!exp_err && wen) model_store(a, sz, wd);
      finish_resp();
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    for (int i = 0; i < 512; i++) ref_mem[i] = 8'h00;
    reset = 1'b1; resp_ready = 1'b1;
    req_valid = 1'b0; req_wen = 1'b0; req_size = 2'd0; req_signed = 1'b0; req_addr = 64'h0; req_wdata = 64'h0;
    u2_req_valid = 1'b0; u2_req_wen = 1'b0; u2_req_size = 2'd0; u2_req_signed = 1'b0;
    u2_req_addr = 64'h0; u2_req_wdata = 64'h0; u2_resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    test_reset();
    test_directed();
    test_hold();
    test_nosplit();
    test_reset_in_beat1();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
